// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: runs ahead of IF/ID, buffers
// {pc+4, instr} pairs and restarts on a MEM-stage redirect.
module if_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [31:0]      redirect_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc_plus_4,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_A = RESET_PC & PC_MASK;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      lat_addr_q, lat_addr_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc4_q [DEPTH];
  logic [31:0]      pc4_d [DEPTH];
  logic [31:0]      ins_q [DEPTH];
  logic [31:0]      ins_d [DEPTH];

  logic [CNT_W:0]   occ;
  logic             has_data;
  logic             push;
  logic             pop;

  // Issue gating: an in-flight fetch always has a reserved slot.
  always_comb begin
    occ       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    imem_req  = rst_n & ~redirect & (occ < DEPTH_C);
    imem_addr = fetch_pc_q;
  end

  // Head view and handshake; redirect masks the head so nothing pops.
  always_comb begin
    has_data      = (count_q != '0);
    out_valid     = has_data & ~redirect;
    out_instr     = has_data ? ins_q[rd_ptr_q] : 32'h0;
    out_pc_plus_4 = has_data ? pc4_q[rd_ptr_q] : 32'h0;
    count         = count_q;
    push          = inflight_q & ~redirect;
    pop           = out_valid & out_ready;
  end

  // Next-state for fetch PC, response tracking and the FIFO.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    lat_addr_d = lat_addr_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc4_d      = pc4_q;
    ins_d      = ins_q;
    if (redirect) begin
      fetch_pc_d = redirect_addr & PC_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        lat_addr_d = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        pc4_d[wr_ptr_q] = lat_addr_q + 32'd4;
        ins_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC_A;
      lat_addr_q <= 32'h0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc4_q[i] <= 32'h0;
        ins_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      lat_addr_q <= lat_addr_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc4_q      <= pc4_d;
      ins_q      <= ins_d;
    end
  end

endmodule
